// File: rtl/core_sequencer_pkg.sv
// Shared types for the multi-cycle RV32I control sequencer: instruction classes,
// sequencer states, writeback/PC mux selects and fault cause codes.
package core_sequencer_pkg;

  typedef enum logic [3:0] {
    ClsAlu, ClsAlui, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsLui, ClsAuipc,
    ClsSystem, ClsIllegal
  } inst_class_t;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt, StFault
  } seq_state_t;

  typedef enum logic [1:0] {WbAlu, WbMem, WbPc4, WbImm} wb_sel_t;

  typedef enum logic [1:0] {PcPlus4, PcBranch, PcJal, PcJalr} pc_sel_t;

  localparam logic [1:0] CauseNone    = 2'd0;
  localparam logic [1:0] CauseIllegal = 2'd1;
  localparam logic [1:0] CauseImem    = 2'd2;
  localparam logic [1:0] CauseDmem    = 2'd3;

  function automatic logic writes_rd(inst_class_t cls);
    return cls inside {ClsAlu, ClsAlui, ClsLoad, ClsLui, ClsAuipc, ClsJal, ClsJalr};
  endfunction

endpackage

// File: rtl/core_sequencer_mem_watchdog.sv
// Wait-cycle counter shared by the fetch and data memory handshakes; expired flags the
// last permitted wait cycle so the caller can still honour an ack arriving in it.
module mem_watchdog #(
  parameter int unsigned Timeout = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expired = (cnt_q == CntW'(Timeout - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I core: FETCH -> DECODE -> EXEC -> [MEM] -> WB,
// with retire counting and terminal HALT/FAULT traps.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [3:0]  inst_class,
  input  logic        branch_taken,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rd_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  seq_state_t  state_q, state_d;
  inst_class_t cls_in, cls_q;
  logic        br_q;
  logic [31:0] instret_q;
  logic [1:0]  cause_q, cause_d;
  logic        wd_clear, wd_tick, wd_expired, mem_ack;

  assign cls_in = inst_class_t'(inst_class);

  // One counter serves both ports; it sits at zero outside the two wait states.
  assign mem_ack  = (state_q == StFetch) ? imem_ack : dmem_ack;
  assign wd_clear = !(state_q inside {StFetch, StMem});
  assign wd_tick  = !wd_clear && !mem_ack;

  mem_watchdog #(
    .Timeout (MEM_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .tick    (wd_tick),
    .expired (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rd_we    = 1'b0;
    wb_sel   = WbAlu;
    pc_we    = 1'b0;
    pc_sel   = PcPlus4;
    retire   = 1'b0;
    unique case (state_q)
      StIdle: if (run) state_d = StFetch;
      StFetch: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        if (imem_ack) begin
          state_d = StDecode;
        end else if (wd_expired) begin
          state_d = StFault;
          cause_d = CauseImem;
        end
      end
      StDecode: begin
        if (cls_in == ClsSystem) begin
          state_d = StHalt;
        end else if (writes_rd(cls_in) || cls_in inside {ClsStore, ClsBranch}) begin
          state_d = StExec;
        end else begin
          // ILLEGAL and the unused encodings both trap
          state_d = StFault;
          cause_d = CauseIllegal;
        end
      end
      StExec: state_d = (cls_q inside {ClsLoad, ClsStore}) ? StMem : StWb;
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == ClsStore);
        if (dmem_ack) begin
          state_d = StWb;
        end else if (wd_expired) begin
          state_d = StFault;
          cause_d = CauseDmem;
        end
      end
      StWb: begin
        pc_we  = 1'b1;
        retire = 1'b1;
        rd_we  = writes_rd(cls_q);
        if (cls_q == ClsLoad)                   wb_sel = WbMem;
        else if (cls_q inside {ClsJal, ClsJalr}) wb_sel = WbPc4;
        else if (cls_q == ClsLui)               wb_sel = WbImm;
        if (cls_q == ClsBranch && br_q) pc_sel = PcBranch;
        else if (cls_q == ClsJal)       pc_sel = PcJal;
        else if (cls_q == ClsJalr)      pc_sel = PcJalr;
        state_d = run ? StFetch : StIdle;
      end
      StHalt, StFault: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cls_q     <= ClsAlu;
      br_q      <= 1'b0;
      instret_q <= '0;
      cause_q   <= CauseNone;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == StDecode) cls_q <= cls_in;
      if (state_q == StExec)   br_q <= branch_taken;
      if (retire)              instret_q <= instret_q + 32'd1;
    end
  end

  assign instret     = instret_q;
  assign halted      = (state_q == StHalt);
  assign fault       = (state_q == StFault);
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-scenario tasks with hand-derived cycle timing.
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, run, branch_taken, imem_ack, dmem_ack;
  logic [3:0]  inst_class;
  logic        imem_req, ir_we, dmem_req, dmem_we, rd_we, pc_we, retire, halted, fault;
  logic [1:0]  wb_sel, pc_sel, fault_cause;
  logic [31:0] instret;

  int vectors = 0;
  int miscompares = 0;

  inst_class_t cls_tbl [5] = '{ClsAlui, ClsLui, ClsAuipc, ClsJal, ClsJalr};
  logic [1:0]  wb_tbl  [5] = '{WbAlu, WbImm, WbAlu, WbPc4, WbPc4};
  logic [1:0]  pc_tbl  [5] = '{PcPlus4, PcPlus4, PcPlus4, PcJal, PcJalr};

  always #5 clk = ~clk;

  core_sequencer #(
    .MEM_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .inst_class   (inst_class),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .ir_we        (ir_we),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .rd_we        (rd_we),
    .wb_sel       (wb_sel),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .retire       (retire),
    .instret      (instret),
    .halted       (halted),
    .fault        (fault),
    .fault_cause  (fault_cause)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in IDLE with run=0; the first edge after run=1 enters FETCH.
  task automatic do_reset(input logic [3:0] cls);
    rst = 1'b1; run = 1'b0; inst_class = cls; branch_taken = 1'b0;
    imem_ack = 1'b1; dmem_ack = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; inst_class = ClsAlu; branch_taken = 1'b1;
    imem_ack = 1'b1; dmem_ack = 1'b1;
    tick(); tick();
    vectors++;
    if ({imem_req, ir_we, dmem_req, dmem_we, rd_we, pc_we, retire, halted, fault} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b want 000000000",
               {imem_req, ir_we, dmem_req, dmem_we, rd_we, pc_we, retire, halted, fault});
    end
    vectors++;
    if (wb_sel !== WbAlu || pc_sel !== PcPlus4 || fault_cause !== CauseNone || instret !== 0) begin
      miscompares++;
      $display("FAIL reset_values: got wb=%0d pc=%0d cause=%0d instret=%0h want 0 0 0 0",
               wb_sel, pc_sel, fault_cause, instret);
    end
  endtask

  task automatic test_alu();
    do_reset(ClsAlu); run = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      vectors++;
      if (retire !== (k % 4 == 0)) begin
        miscompares++;
        $display("FAIL alu_retire c%0d: got %b want %b", k, retire, (k % 4 == 0));
      end
      vectors++;
      if (ir_we !== (k % 4 == 1) || imem_req !== (k % 4 == 1)) begin
        miscompares++;
        $display("FAIL alu_fetch c%0d: got req=%b ir_we=%b want %b", k, imem_req, ir_we,
                 (k % 4 == 1));
      end
      if (k % 4 == 0) begin
        vectors++;
        if (rd_we !== 1'b1 || pc_we !== 1'b1 || wb_sel !== WbAlu || pc_sel !== PcPlus4) begin
          miscompares++;
          $display("FAIL alu_wb c%0d: got rd_we=%b pc_we=%b wb=%0d pc=%0d want 1 1 0 0",
                   k, rd_we, pc_we, wb_sel, pc_sel);
        end
      end
    end
    tick();
    vectors++;
    if (instret !== 32'd3) begin
      miscompares++;
      $display("FAIL alu_instret: got %0d want 3", instret);
    end
  endtask

  task automatic test_load();
    int reqs = 0;
    int first = 0;
    do_reset(ClsLoad); run = 1'b1; dmem_ack = 1'b0;
    for (int k = 1; k <= 20 && reqs < 4; k++) begin
      tick();
      if (dmem_req) begin
        reqs++;
        if (reqs == 1) first = k;
        vectors++;
        if (dmem_we !== 1'b0) begin
          miscompares++;
          $display("FAIL load_we c%0d: got %b want 0", k, dmem_we);
        end
        if (reqs == 4) dmem_ack = 1'b1;
      end
    end
    vectors++;
    if (reqs != 4 || first != 4) begin
      miscompares++;
      $display("FAIL load_req: got %0d cycles from c%0d want 4 from c4", reqs, first);
    end
    tick();
    vectors++;
    if (retire !== 1'b1 || rd_we !== 1'b1 || wb_sel !== WbMem || dmem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL load_wb: got retire=%b rd_we=%b wb=%0d req=%b want 1 1 1 0",
               retire, rd_we, wb_sel, dmem_req);
    end
  endtask

  task automatic test_store_branch();
    do_reset(ClsStore); run = 1'b1;
    repeat (4) tick();
    vectors++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
      miscompares++;
      $display("FAIL store_mem: got req=%b we=%b want 1 1", dmem_req, dmem_we);
    end
    tick();
    vectors++;
    if (retire !== 1'b1 || rd_we !== 1'b0 || pc_we !== 1'b1) begin
      miscompares++;
      $display("FAIL store_wb: got retire=%b rd_we=%b pc_we=%b want 1 0 1", retire, rd_we, pc_we);
    end
    inst_class = ClsBranch; branch_taken = 1'b1;
    repeat (4) tick();
    vectors++;
    if (retire !== 1'b1 || rd_we !== 1'b0 || pc_sel !== PcBranch) begin
      miscompares++;
      $display("FAIL branch_taken: got retire=%b rd_we=%b pc=%0d want 1 0 1", retire, rd_we, pc_sel);
    end
    branch_taken = 1'b0;
    repeat (4) tick();
    vectors++;
    if (retire !== 1'b1 || rd_we !== 1'b0 || pc_sel !== PcPlus4) begin
      miscompares++;
      $display("FAIL branch_not_taken: got retire=%b rd_we=%b pc=%0d want 1 0 0",
               retire, rd_we, pc_sel);
    end
  endtask

  task automatic test_wb_decode();
    do_reset(cls_tbl[0]); run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inst_class = cls_tbl[i];
      repeat (4) tick();
      vectors++;
      if (retire !== 1'b1 || rd_we !== 1'b1 || wb_sel !== wb_tbl[i] || pc_sel !== pc_tbl[i] ||
          instret !== 32'(i)) begin
        miscompares++;
        $display("FAIL wb_decode[%0d]: got retire=%b rd_we=%b wb=%0d pc=%0d instret=%0d want 1 1 %0d %0d %0d",
                 i, retire, rd_we, wb_sel, pc_sel, instret, wb_tbl[i], pc_tbl[i], i);
      end
    end
  endtask

  task automatic test_imem_timeout();
    do_reset(ClsAlu); run = 1'b1; imem_ack = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      vectors++;
      if (imem_req !== 1'b1 || fault !== 1'b0) begin
        miscompares++;
        $display("FAIL imem_wait c%0d: got req=%b fault=%b want 1 0", k, imem_req, fault);
      end
    end
    tick();
    vectors++;
    if (fault !== 1'b1 || fault_cause !== CauseImem || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL imem_timeout: got fault=%b cause=%0d req=%b want 1 2 0",
               fault, fault_cause, imem_req);
    end
    imem_ack = 1'b1; run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if ({imem_req, ir_we, dmem_req, pc_we, retire, rd_we} !== 6'b0 || fault !== 1'b1) begin
        miscompares++;
        $display("FAIL fault_quiet %0d: got strobes=%b fault=%b want 000000 1",
                 k, {imem_req, ir_we, dmem_req, pc_we, retire, rd_we}, fault);
      end
    end
  endtask

  task automatic test_timeout_boundary();
    do_reset(ClsAlu); run = 1'b1; imem_ack = 1'b0;
    repeat (16) tick();
    imem_ack = 1'b1;
    #1;
    vectors++;
    if (ir_we !== 1'b1) begin
      miscompares++;
      $display("FAIL late_ack_ir_we: got %b want 1", ir_we);
    end
    tick();
    vectors++;
    if (fault !== 1'b0) begin
      miscompares++;
      $display("FAIL late_ack_fault: got %b want 0", fault);
    end
    repeat (2) tick();
    vectors++;
    if (retire !== 1'b1) begin
      miscompares++;
      $display("FAIL late_ack_retire: got %b want 1", retire);
    end
  endtask

  task automatic test_dmem_timeout();
    do_reset(ClsLoad); run = 1'b1; dmem_ack = 1'b0;
    repeat (3) tick();
    for (int k = 1; k <= 16; k++) begin
      tick();
      vectors++;
      if (dmem_req !== 1'b1) begin
        miscompares++;
        $display("FAIL dmem_wait %0d: got %b want 1", k, dmem_req);
      end
    end
    tick();
    vectors++;
    if (fault !== 1'b1 || fault_cause !== CauseDmem || dmem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL dmem_timeout: got fault=%b cause=%0d req=%b want 1 3 0",
               fault, fault_cause, dmem_req);
    end
  endtask

  task automatic test_illegal();
    do_reset(ClsAlu); run = 1'b1;
    repeat (4) tick();
    inst_class = ClsIllegal;
    repeat (3) tick();
    vectors++;
    if (fault !== 1'b1 || fault_cause !== CauseIllegal || instret !== 32'd1 || retire !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal: got fault=%b cause=%0d instret=%0d retire=%b want 1 1 1 0",
               fault, fault_cause, instret, retire);
    end
  endtask

  task automatic test_system();
    do_reset(ClsSystem); run = 1'b1;
    repeat (3) tick();
    vectors++;
    if (halted !== 1'b1 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL system_halt: got halted=%b fault=%b want 1 0", halted, fault);
    end
    for (int k = 0; k < 6; k++) begin
      run = (k % 2 == 1);
      tick();
      vectors++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || retire !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_sticky %0d: got halted=%b req=%b retire=%b want 1 0 0",
                 k, halted, imem_req, retire);
      end
    end
  endtask

  task automatic test_run_drop();
    do_reset(ClsLoad); run = 1'b1; dmem_ack = 1'b0;
    repeat (4) tick();
    run = 1'b0;
    tick();
    dmem_ack = 1'b1;
    tick();
    vectors++;
    if (retire !== 1'b1 || pc_we !== 1'b1) begin
      miscompares++;
      $display("FAIL run_drop_retire: got retire=%b pc_we=%b want 1 1", retire, pc_we);
    end
    tick();
    vectors++;
    if (imem_req !== 1'b0 || retire !== 1'b0 || instret !== 32'd1) begin
      miscompares++;
      $display("FAIL run_drop_idle: got req=%b retire=%b instret=%0d want 0 0 1",
               imem_req, retire, instret);
    end
    repeat (3) tick();
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL run_drop_stay: got req=%b want 0", imem_req);
    end
  endtask

  task automatic test_reset_abort();
    do_reset(ClsAlu); run = 1'b1;
    repeat (4) tick();
    inst_class = ClsLoad; dmem_ack = 1'b0;
    repeat (4) tick();
    vectors++;
    if (dmem_req !== 1'b1 || instret !== 32'd1) begin
      miscompares++;
      $display("FAIL abort_setup: got req=%b instret=%0d want 1 1", dmem_req, instret);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({imem_req, ir_we, dmem_req, dmem_we, rd_we, pc_we, retire} !== 7'b0 || instret !== 0) begin
      miscompares++;
      $display("FAIL abort_mem: got strobes=%b instret=%0d want 0000000 0",
               {imem_req, ir_we, dmem_req, dmem_we, rd_we, pc_we, retire}, instret);
    end
    tick(); rst = 1'b0; run = 1'b0;
    tick();
    vectors++;
    if (imem_req !== 1'b0 || dmem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: got imem=%b dmem=%b want 0 0", imem_req, dmem_req);
    end
  endtask

  task automatic test_wrap();
    // Wrap through WB
    do_reset(ClsAlu);
    force dut.instret_q = 32'hFFFF_FFFF;
    tick();
    release dut.instret_q;
    run = 1'b1;
    repeat (4) tick();
    vectors++;
    if (retire !== 1'b1 || instret !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL wrap_wb: got retire=%b instret=%0h want 1 ffffffff", retire, instret);
    end
    tick();
    vectors++;
    if (instret !== 32'd0) begin
      miscompares++;
      $display("FAIL wrap_zero: got %0h want 0", instret);
    end
    // Reset arriving in WB
    do_reset(ClsAlu);
    force dut.instret_q = 32'hFFFF_FFFF;
    tick();
    release dut.instret_q;
    run = 1'b1;
    repeat (4) tick();
    vectors++;
    if (retire !== 1'b1) begin
      miscompares++;
      $display("FAIL wb_rst_setup: got retire=%b want 1", retire);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (retire !== 1'b0 || pc_we !== 1'b0 || rd_we !== 1'b0 || instret !== 32'd0) begin
      miscompares++;
      $display("FAIL wb_rst: got retire=%b pc_we=%b rd_we=%b instret=%0h want 0 0 0 0",
               retire, pc_we, rd_we, instret);
    end
    tick(); rst = 1'b0; run = 1'b0;
    tick();
    vectors++;
    if (instret !== 32'd0 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL wb_rst_idle: got instret=%0h req=%b want 0 0", instret, imem_req);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_branch();
    test_wb_decode();
    test_imem_timeout();
    test_timeout_boundary();
    test_dmem_timeout();
    test_illegal();
    test_system();
    test_run_drop();
    test_reset_abort();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
